// File: rtl/hex_display_scanner_if.sv
// Display-side bundle for hex_display_scanner: word/control inputs and the
// active-low anode, segment and decimal-point lines of the 8-digit display.
interface hex_display_scanner_if;
    logic [31:0] value;
    logic        freeze;
    logic        blank;
    logic [7:0]  dp_mask;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    modport master (
        output value, freeze, blank, dp_mask,
        input  AN, SEG, DP
    );

    modport slave (
        input  value, freeze, blank, dp_mask,
        output AN, SEG, DP
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Scans a 32-bit word as 8 hex digits onto a common-anode 7-segment display,
// capturing the word once per frame. Define HEX_DISPLAY_LZB_EN for leading-zero blanking.
module hex_display_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   CLK,
    input  logic                   reset,
    hex_display_scanner_if.slave   disp
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       idx;
    logic [31:0]      snap;
    logic             tick;
    logic [3:0]       nibble;
    logic             lit;

    assign tick   = (div_cnt == DIV_LAST);
    assign nibble = snap[{idx, 2'b00} +: 4];

`ifdef HEX_DISPLAY_LZB_EN
    // Highest nonzero nibble; digit 0 stays lit even when snap is all zero.
    logic [2:0] msd;

    always_comb begin
        msd = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (snap[4*k +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
    end

    assign lit = !disp.blank && (idx <= msd);
`else
    assign lit = !disp.blank;
`endif

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h08;
            4'hB:    decode = 7'h03;
            4'hC:    decode = 7'h46;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    // value is only captured at the last tick of a frame, so a digit pattern never tears.
    always_ff @(posedge CLK) begin
        if (reset) begin
            div_cnt  <= '0;
            idx      <= 3'd0;
            snap     <= 32'h0;
            disp.AN  <= 8'hFF;
            disp.SEG <= 7'h7F;
            disp.DP  <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
                if (idx == 3'd7 && !disp.freeze) begin
                    snap <= disp.value;
                end
            end
            disp.AN  <= lit ? ~(8'b1 << idx) : 8'hFF;
            disp.SEG <= decode(nibble);
            disp.DP  <= ~disp.dp_mask[idx];
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner: a frame-arithmetic model predicts
// every output cycle, a separate monitor pops and compares after each edge.
module tb_hex_display_scanner;

    localparam int RD    = 4;
    localparam int FRAME = 8 * RD;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic CLK = 1'b0;
    logic reset;

    hex_display_scanner_if bus ();

    hex_display_scanner #(.REFRESH_DIV(RD)) dut (
        .CLK   (CLK),
        .reset (reset),
        .disp  (bus)
    );

    always #5 CLK = ~CLK;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    exp_t        exp_q [$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          armed        = 1'b0;
    int          model_cyc    = 0;
    logic [31:0] model_snap   = 32'h0;

    // Drive one cycle of inputs and queue what the display must show after the next edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] val, input logic frz,
                                 input logic blk, input logic [7:0] dpm);
        exp_t e;
        int   slot;
        bit   show;
        @(negedge CLK);
        reset       = rst;
        bus.value   = val;
        bus.freeze  = frz;
        bus.blank   = blk;
        bus.dp_mask = dpm;
        if (rst) begin
            e          = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
            model_cyc  = 0;
            model_snap = 32'h0;
        end else begin
            slot = (model_cyc / RD) % 8;
            show = !blk;
`ifdef HEX_DISPLAY_LZB_EN
            begin
                int top;
                top = 0;
                for (int k = 1; k < 8; k++) begin
                    if (model_snap[4*k +: 4] != 4'h0) top = k;
                end
                if (slot > top) show = 1'b0;
            end
`endif
            e.an  = show ? ~(8'h01 << slot) : 8'hFF;
            e.seg = seg_tab[model_snap[4*slot +: 4]];
            e.dp  = ~dpm[slot];
            if ((model_cyc % FRAME) == FRAME - 1 && !frz) begin
                model_snap = val;
            end
            model_cyc++;
        end
        exp_q.push_back(e);
        armed = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (bus.AN !== e.an) begin
            tests_failed++;
            $display("[TB] FAIL AN at %0t: got %h, expected %h", $time, bus.AN, e.an);
        end
        tests_run++;
        if (bus.SEG !== e.seg) begin
            tests_failed++;
            $display("[TB] FAIL SEG at %0t: got %h, expected %h (AN=%h)", $time, bus.SEG, e.seg, bus.AN);
        end
        tests_run++;
        if (bus.DP !== e.dp) begin
            tests_failed++;
            $display("[TB] FAIL DP at %0t: got %b, expected %b (AN=%h)", $time, bus.DP, e.dp, bus.AN);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (armed) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL scoreboard: got empty queue, expected a pending entry");
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        reset       = 1'b1;
        bus.value   = 32'h0;
        bus.freeze  = 1'b0;
        bus.blank   = 1'b0;
        bus.dp_mask = 8'h00;

        repeat (3) applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 8'h00);
        repeat (3 * FRAME) applyStimulus(1'b0, 32'h1234ABCD, 1'b0, 1'b0, 8'h00);
        repeat (3 * FRAME) applyStimulus(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h00);
        repeat (2 * FRAME) applyStimulus(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 8'h00);

        repeat (11) applyStimulus(1'b0, 32'h0F1E2D3C, 1'b0, 1'b0, 8'h00);
        repeat (13) applyStimulus(1'b0, 32'h0F1E2D3C, 1'b0, 1'b1, 8'h00);
        repeat (2 * FRAME) applyStimulus(1'b0, 32'h0F1E2D3C, 1'b0, 1'b0, 8'h05);

        repeat (2 * FRAME) applyStimulus(1'b0, 32'h000000A5, 1'b0, 1'b0, 8'h00);
        while (((model_cyc / RD) % 8) != 5) applyStimulus(1'b0, 32'h000000A5, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 32'h000000A5, 1'b0, 1'b0, 8'h00);
        repeat (2 * FRAME) applyStimulus(1'b0, 32'h000000A5, 1'b0, 1'b0, 8'h00);

        repeat (1200) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 299) == 0), v, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        @(posedge CLK);
        #2;
        armed = 1'b0;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
